// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared RV32I load/store encodings and MEM-stage FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/load_store_align.sv
// ============================================================================
// Module  : load_store_align
// Brief   : Byte-lane steering for stores and lane select/extension for loads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] raw_rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] lane_wdata,
    output logic [XLEN-1:0] load_data,
    output logic            aligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // funct3[1:0] encodes the access size for both loads and stores
    always_comb begin
        aligned    = 1'b0;
        be         = 4'b0000;
        lane_wdata = store_data;
        unique case (funct3[1:0])
            2'b00: begin
                aligned    = 1'b1;
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                aligned    = ~addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{store_data[15:0]}};
            end
            2'b10: begin
                aligned    = (addr_lo == 2'b00);
                be         = 4'b1111;
                lane_wdata = store_data;
            end
            default: begin
                aligned    = 1'b0;
                be         = 4'b0000;
                lane_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        unique case (addr_lo)
            2'b00:   w_byte = raw_rdata[7:0];
            2'b01:   w_byte = raw_rdata[15:8];
            2'b10:   w_byte = raw_rdata[23:16];
            default: w_byte = raw_rdata[31:24];
        endcase
        w_half = addr_lo[1] ? raw_rdata[31:16] : raw_rdata[15:0];
    end

    always_comb begin
        load_data = raw_rdata;
        case (funct3)
            FUNCT3_LB:  load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            FUNCT3_LH:  load_data = {{(XLEN-16){w_half[15]}}, w_half};
            FUNCT3_LBU: load_data = {{(XLEN-8){1'b0}}, w_byte};
            FUNCT3_LHU: load_data = {{(XLEN-16){1'b0}}, w_half};
            default:    load_data = raw_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// ============================================================================
// Module  : memory_stage
// Brief   : RV32I MEM stage: data-memory access FSM, bus watchdog, MEM/WB reg.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_stage
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Valid_M,
    input  logic [4:0]      RD_M,
    input  logic            RegWriteEn_M,
    input  logic            MemtoReg_M,
    input  logic            JAL_M,
    input  logic            MemRead_M,
    input  logic            MemWrite_M,
    input  logic [2:0]      Funct3_M,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] PCPlus4M,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            StallM,
    output logic            MisalignM,
    output logic            BusErrM,
    output logic [4:0]      RD_W,
    output logic            RegWriteEn_W,
    output logic            MemtoReg_W,
    output logic            JAL_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYC);

    mem_state_t      r_state;
    mem_state_t      w_next_state;
    logic [7:0]      r_wait_cnt;
    logic            w_is_mem;
    logic            w_aligned;
    logic            w_mem_op;
    logic            w_misalign;
    logic            w_abort;
    logic            w_bubble;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_lane_wdata;
    logic [XLEN-1:0] w_load_data;

    load_store_align #(
        .XLEN (XLEN)
    ) u_align (
        .addr_lo    (ALU_ResultM[1:0]),
        .funct3     (Funct3_M),
        .store_data (WriteDataM),
        .raw_rdata  (dmem_rdata),
        .be         (w_be),
        .lane_wdata (w_lane_wdata),
        .load_data  (w_load_data),
        .aligned    (w_aligned)
    );

    assign w_is_mem   = Valid_M & (MemRead_M | MemWrite_M);
    assign w_mem_op   = w_is_mem & w_aligned;
    assign w_misalign = w_is_mem & ~w_aligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_mem_op && !dmem_ready) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ready || w_abort) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // rst gates the IDLE request so an asserted reset drops the port at once
    always_comb begin
        dmem_req = 1'b0;
        w_abort  = 1'b0;
        unique case (r_state)
            IDLE: begin
                dmem_req = w_mem_op & rst;
            end
            WAIT: begin
                dmem_req = 1'b1;
                w_abort  = ~dmem_ready & (r_wait_cnt == C_TIMEOUT);
            end
            default: begin
                dmem_req = 1'b0;
                w_abort  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == IDLE) begin
            r_wait_cnt <= (w_mem_op && !dmem_ready) ? 8'd1 : 8'd0;
        end else if (dmem_ready || w_abort) begin
            r_wait_cnt <= 8'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign StallM     = dmem_req & ~dmem_ready & ~w_abort;
    assign MisalignM  = w_misalign;
    assign BusErrM    = w_abort;
    assign dmem_we    = dmem_req & MemWrite_M;
    assign dmem_addr  = {ALU_ResultM[XLEN-1:2], 2'b00};
    assign dmem_be    = dmem_req ? w_be : 4'b0000;
    assign dmem_wdata = dmem_we ? w_lane_wdata : '0;

    // A stalled instruction stays in EX/MEM, so W sees bubbles until it completes
    assign w_bubble = StallM | ~Valid_M | w_misalign | w_abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RD_W         <= 5'd0;
            RegWriteEn_W <= 1'b0;
            MemtoReg_W   <= 1'b0;
            JAL_W        <= 1'b0;
            PCPlus4W     <= '0;
            ALU_ResultW  <= '0;
            ReadDataW    <= '0;
        end else if (w_bubble) begin
            RD_W         <= 5'd0;
            RegWriteEn_W <= 1'b0;
            MemtoReg_W   <= 1'b0;
            JAL_W        <= 1'b0;
            PCPlus4W     <= '0;
            ALU_ResultW  <= '0;
            ReadDataW    <= '0;
        end else begin
            RD_W         <= RD_M;
            RegWriteEn_W <= RegWriteEn_M;
            MemtoReg_W   <= MemtoReg_M;
            JAL_W        <= JAL_M;
            PCPlus4W     <= PCPlus4M;
            ALU_ResultW  <= ALU_ResultM;
            ReadDataW    <= MemRead_M ? w_load_data : '0;
        end
    end

endmodule

`default_nettype wire
